// File: rtl/seven_seg_scanner_if.sv
// Display-side bundle for the 6-digit scanner: BCD digits and controls in,
// multiplexed anode/cathode drive out.
interface seven_seg_scanner_if;
    logic [3:0] s1;
    logic [3:0] s2;
    logic [3:0] m1;
    logic [3:0] m2;
    logic [3:0] h1;
    logic [3:0] h2;
    logic       blank;
    logic       lamp_test;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output s1, s2, m1, m2, h1, h2, blank, lamp_test,
        input  an, seg, dp
    );

    modport slave (
        input  s1, s2, m1, m2, h1, h2, blank, lamp_test,
        output an, seg, dp
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for a 6-digit common-anode 7-segment clock display
// with per-frame digit snapshots, leading-zero blanking and blinking separators.
module seven_seg_scanner #(
    parameter int REFRESH_DIV = 100_000,
    parameter int DP_HALF     = 50_000_000,
    parameter int BLANK_LZ    = 1
) (
    input logic                clk,
    input logic                rst,
    seven_seg_scanner_if.slave disp
);

    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (DP_HALF > 1) ? $clog2(DP_HALF) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(DP_HALF - 1);

    localparam logic [5:0] AN_OFF  = 6'b111111;
    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [6:0] SEG_ALL = 7'b0000000;

    typedef enum logic [2:0] {
        SLOT_S1 = 3'd0,
        SLOT_S2 = 3'd1,
        SLOT_M1 = 3'd2,
        SLOT_M2 = 3'd3,
        SLOT_H1 = 3'd4,
        SLOT_H2 = 3'd5
    } slot_e;

    logic [RW-1:0] refresh_cnt;
    logic [BW-1:0] blink_cnt;
    logic          dp_phase;
    slot_e         idx;

    logic [3:0] snap_s1;
    logic [3:0] snap_s2;
    logic [3:0] snap_m1;
    logic [3:0] snap_m2;
    logic [3:0] snap_h1;
    logic [3:0] snap_h2;

    logic       tick;
    logic       blink_tick;
    logic [3:0] digit;
    logic [5:0] an_next;
    logic [6:0] seg_next;
    logic       dp_next;

    // Active-low gfedcba; non-decimal codes show a lone dash.
    function automatic logic [6:0] decode_bcd(input logic [3:0] value);
        logic [6:0] segs;
        case (value)
            4'd0:    segs = 7'h40;
            4'd1:    segs = 7'h79;
            4'd2:    segs = 7'h24;
            4'd3:    segs = 7'h30;
            4'd4:    segs = 7'h19;
            4'd5:    segs = 7'h12;
            4'd6:    segs = 7'h02;
            4'd7:    segs = 7'h78;
            4'd8:    segs = 7'h00;
            4'd9:    segs = 7'h10;
            default: segs = 7'h3F;
        endcase
        return segs;
    endfunction

    assign tick       = (refresh_cnt == REFRESH_LAST);
    assign blink_tick = (blink_cnt == BLINK_LAST);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        digit = snap_s1;
        case (idx)
            SLOT_S1: digit = snap_s1;
            SLOT_S2: digit = snap_s2;
            SLOT_M1: digit = snap_m1;
            SLOT_M2: digit = snap_m2;
            SLOT_H1: digit = snap_h1;
            SLOT_H2: digit = snap_h2;
            default: digit = snap_s1;
        endcase
    end

    always_comb begin
        an_next  = ~(6'b000001 << idx);
        seg_next = decode_bcd(digit);
        dp_next  = ~(dp_phase && (idx == SLOT_M1 || idx == SLOT_H1));

        if (BLANK_LZ != 0 && idx == SLOT_H2 && digit == 4'd0) begin
            seg_next = SEG_OFF;
            dp_next  = 1'b1;
        end

        // Lamp test wins over blank so a dark display can still be checked.
        if (disp.lamp_test) begin
            seg_next = SEG_ALL;
            dp_next  = 1'b0;
        end else if (disp.blank) begin
            an_next  = AN_OFF;
            seg_next = SEG_OFF;
            dp_next  = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            refresh_cnt <= '0;
            blink_cnt   <= '0;
            dp_phase    <= 1'b0;
            idx         <= SLOT_S1;
            // NOTE: the snapshot bank is reset on purpose so the first frame
            // after reset shows zeros instead of stale data.
            snap_s1     <= '0;
            snap_s2     <= '0;
            snap_m1     <= '0;
            snap_m2     <= '0;
            snap_h1     <= '0;
            snap_h2     <= '0;
            disp.an     <= AN_OFF;
            disp.seg    <= SEG_OFF;
            disp.dp     <= 1'b1;
        end else begin
            refresh_cnt <= tick ? '0 : refresh_cnt + 1'b1;
            blink_cnt   <= blink_tick ? '0 : blink_cnt + 1'b1;
            if (blink_tick) begin
                dp_phase <= ~dp_phase;
            end

            if (tick) begin
                if (idx == SLOT_H2) begin
                    idx     <= SLOT_S1;
                    // Capture all six digits together so a frame never tears.
                    snap_s1 <= disp.s1;
                    snap_s2 <= disp.s2;
                    snap_m1 <= disp.m1;
                    snap_m2 <= disp.m2;
                    snap_h1 <= disp.h1;
                    snap_h2 <= disp.h2;
                end else begin
                    idx <= slot_e'(idx + 3'd1);
                end
            end

            disp.an  <= an_next;
            disp.seg <= seg_next;
            disp.dp  <= dp_next;
        end
    end

endmodule
